// File: rtl/ser_loader.sv
// Serial boot loader: polls a serial receiver over the stb/we/addr/ack bus,
// parses a length/address/payload/checksum image and writes the payload to
// memory as 32-bit little-endian words through the same bus.
module ser_loader #(
  parameter logic [31:0] SER_BASE = 32'hFFFFFFC8,
  parameter int unsigned RDY_BIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StStat, StData, StProc, StWr, StFin} state_e;
  typedef enum logic [1:0] {PhHdr, PhPay, PhSum} phase_e;

  state_e      state_q;
  phase_e      phase_q;
  logic [31:0] cnt_q;    // header byte index, then payload byte index
  logic [31:0] len_q;
  logic [31:0] base_q;
  logic [31:0] wcnt_q;
  logic [31:0] word_q;
  logic [7:0]  csum_q;
  logic [7:0]  byte_q;
  logic        bad_q;    // checksum verdict, published together with done
  logic        stb_q, we_q, busy_q, done_q, err_q;
  logic [31:0] addr_q, dout_q;

  logic [4:0]  lane_sh;
  logic [31:0] wr_addr;
  logic        pay_flush;

  assign lane_sh   = {cnt_q[1:0], 3'b000};
  assign wr_addr   = base_q + {wcnt_q[29:0], 2'b00};
  assign pay_flush = (cnt_q[1:0] == 2'd3) || (cnt_q == len_q - 32'd1);

  assign bus_stb      = stb_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_data_out = dout_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  // Loader FSM; every bus state raises stb only after a cycle with stb low,
  // which guarantees the idle gap between transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      phase_q <= PhHdr;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      byte_q  <= '0;
      bad_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            csum_q  <= '0;
            phase_q <= PhHdr;
            len_q   <= '0;
            base_q  <= '0;
            wcnt_q  <= '0;
            word_q  <= '0;
            state_q <= StStat;
          end
        end
        StStat: begin
          if (!stb_q) begin
            stb_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= SER_BASE + 32'd4;
          end else if (bus_ack) begin
            stb_q   <= 1'b0;
            state_q <= bus_data_in[RDY_BIT] ? StData : StStat;
          end
        end
        StData: begin
          if (!stb_q) begin
            stb_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= SER_BASE;
          end else if (bus_ack) begin
            stb_q   <= 1'b0;
            byte_q  <= bus_data_in[7:0];
            state_q <= StProc;
          end
        end
        StProc: begin
          unique case (phase_q)
            PhHdr: begin
              if (!cnt_q[2]) begin
                len_q[lane_sh +: 8] <= byte_q;
              end else if (cnt_q[1:0] == 2'd0) begin
                base_q[7:0] <= {byte_q[7:2], 2'b00};
              end else begin
                base_q[lane_sh +: 8] <= byte_q;
              end
              if (cnt_q[2:0] == 3'd7) begin
                cnt_q   <= '0;
                phase_q <= (len_q != 32'd0) ? PhPay : PhSum;
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
              state_q <= StStat;
            end
            PhPay: begin
              word_q[lane_sh +: 8] <= byte_q;
              csum_q  <= csum_q ^ byte_q;
              cnt_q   <= cnt_q + 32'd1;
              state_q <= pay_flush ? StWr : StStat;
            end
            default: begin
              bad_q   <= (byte_q != csum_q);
              state_q <= StFin;
            end
          endcase
        end
        StWr: begin
          if (!stb_q) begin
            stb_q  <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= wr_addr;
            dout_q <= word_q;
          end else if (bus_ack) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            wcnt_q  <= wcnt_q + 32'd1;
            word_q  <= '0;
            // cnt_q already counts the bytes consumed so far
            phase_q <= (cnt_q != len_q) ? PhPay : PhSum;
            state_q <= StStat;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= bad_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_loader.sv
// Directed bench for ser_loader with a behavioural serial receiver and a
// write logger on the bus.
module tb_ser_loader;

  localparam logic [31:0] SerBase = 32'hFFFFFFC8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        bus_stb, bus_we, bus_ack, busy, done, err;
  logic [31:0] bus_addr, bus_data_out, bus_data_in;

  int errors = 0;
  int checks = 0;

  // Serial model state
  logic [7:0] stream [256];
  int   idx = 0;
  int   hold = 0;
  int   delay = 0;
  logic rdy_en = 1'b1;
  logic rdy;
  logic last_rdy = 1'b0;
  int   data_reads = 0;
  int   stat_zero = 0;
  int   seq_viol = 0;
  int   stb_viol = 0;
  logic prev_stb = 1'b0;

  // Write log
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  int   wn = 0;

  logic [7:0] img [];
  int   wbase, dbase, zbase;
  bit   seen;

  ser_loader #(.SER_BASE(SerBase), .RDY_BIT(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_ack(bus_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rdy         = rdy_en && (hold == 0);
  assign bus_ack     = bus_stb;
  assign bus_data_in = (bus_addr == SerBase) ? {24'h0, stream[idx[7:0]]} : {31'h0, rdy};

  // Serial receiver, stb-gap monitor and write logger
  always @(posedge clk) begin
    prev_stb <= bus_stb;
    if (bus_stb && prev_stb) stb_viol <= stb_viol + 1;
    if (hold != 0) hold <= hold - 1;
    if (bus_stb && bus_ack && !bus_we) begin
      if (bus_addr == SerBase) begin
        idx        <= idx + 1;
        data_reads <= data_reads + 1;
        hold       <= delay;
        if (!last_rdy) seq_viol <= seq_viol + 1;
        last_rdy   <= 1'b0;
      end else if (bus_addr == SerBase + 32'd4) begin
        if (!rdy) stat_zero <= stat_zero + 1;
        last_rdy <= rdy;
      end
    end
    if (bus_stb && bus_ack && bus_we) begin
      wa[wn] <= bus_addr;
      wd[wn] <= bus_data_out;
      wn     <= wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stage();
    for (int i = 0; i < img.size(); i++) stream[8'(idx + i)] = img[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
  endtask

  // Standard load: stage image, start, wait, then check done shape
  task automatic run_load(input string tag, input int lim);
    wbase = wn;
    dbase = data_reads;
    zbase = stat_zero;
    stage();
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lim, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_outputs", 32'({bus_stb, bus_we, busy, done, err} | |bus_addr | |bus_data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Good image: checksum 11^22^33^44^55^66 = 77
    img = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load("t1", 600);
    chk("t1_nwr", 32'(wn - wbase), 32'd2);
    chk("t1_a0", wa[wbase], 32'h00001000);
    chk("t1_d0", wd[wbase], 32'h44332211);
    chk("t1_a1", wa[wbase+1], 32'h00001004);
    chk("t1_d1", wd[wbase+1], 32'h00006655);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_reads", 32'(data_reads - dbase), 32'd15);

    // Bad checksum: same writes, err latched
    img[14] = 8'h5A;
    run_load("t2", 600);
    chk("t2_nwr", 32'(wn - wbase), 32'd2);
    chk("t2_d0", wd[wbase], 32'h44332211);
    chk("t2_d1", wd[wbase+1], 32'h00006655);
    chk("t2_err", 32'(err), 32'd1);
    repeat (10) @(negedge clk);
    chk("t2_err_held", 32'(err), 32'd1);

    // L=0, A=0x2000: no writes, 9 reads; start clears err
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    wbase = wn;
    dbase = data_reads;
    stage();
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'd0);
    wait_done(400, seen);
    chk("t3_done_seen", 32'(seen), 32'd1);
    chk("t3_nwr", 32'(wn - wbase), 32'd0);
    chk("t3_reads", 32'(data_reads - dbase), 32'd9);
    chk("t3_err", 32'(err), 32'd0);

    // Receiver not ready for 20 cycles before each byte
    delay = 20;
    @(negedge clk);
    run_load("t4", 3000);
    chk("t4_reads", 32'(data_reads - dbase), 32'd9);
    chk("t4_polled", 32'(stat_zero - zbase >= 45), 32'd1);
    chk("t4_nwr", 32'(wn - wbase), 32'd0);
    delay = 0;
    repeat (25) @(negedge clk);

    // Unaligned load address is truncated to 0x1000
    img = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h03, 8'h10, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load("t5", 600);
    chk("t5_a0", wa[wbase], 32'h00001000);
    chk("t5_a1", wa[wbase+1], 32'h00001004);

    // Address wrap: 0xFFFFFFFC then 0x00000000; checksum 01^..^08 = 08
    img = '{8'h08, 8'h00, 8'h00, 8'h00, 8'hFC, 8'hFF, 8'hFF, 8'hFF,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    run_load("t6", 600);
    chk("t6_nwr", 32'(wn - wbase), 32'd2);
    chk("t6_a0", wa[wbase], 32'hFFFFFFFC);
    chk("t6_d0", wd[wbase], 32'h04030201);
    chk("t6_a1", wa[wbase+1], 32'h00000000);
    chk("t6_d1", wd[wbase+1], 32'h08070605);
    chk("t6_err", 32'(err), 32'd0);

    // Asynchronous reset mid-payload, then a clean reload
    img = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    dbase = data_reads;
    stage();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (data_reads - dbase >= 10) seen = 1'b1;
    end
    chk("t7_reached_payload", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t7_async_zero", 32'({bus_stb, bus_we, busy, done, err} | |bus_addr | |bus_data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    run_load("t8", 600);
    chk("t8_nwr", 32'(wn - wbase), 32'd2);
    chk("t8_a0", wa[wbase], 32'h00001000);
    chk("t8_d0", wd[wbase], 32'h44332211);
    chk("t8_d1", wd[wbase+1], 32'h00006655);
    chk("t8_err", 32'(err), 32'd0);

    // Whole-run bus protocol properties
    chk("stb_gap", 32'(stb_viol), 32'd0);
    chk("data_after_rdy", 32'(seq_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
